// File: rtl/dm_controller_if.sv
// Host/core signal bundle for dm_controller: the host side drives preload, start and dump,
// and the core side drives the memory port, while the controller answers on the outputs.
interface dm_controller_if #(
    parameter int AW = 8
);
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          start;
    logic          dump;
    logic          dm_en;
    logic [15:0]   dar_out;
    logic [15:0]   bus_out;
    logic          end_process;
    logic [7:0]    dm_out;
    logic [1:0]    status;
    logic [7:0]    host_rdata;
    logic          host_valid;
    logic          timeout;
    logic          addr_err;

    modport master (
        output host_we, host_addr, host_wdata, start, dump,
        output dm_en, dar_out, bus_out, end_process,
        input  dm_out, status, host_rdata, host_valid, timeout, addr_err
    );

    modport slave (
        input  host_we, host_addr, host_wdata, start, dump,
        input  dm_en, dar_out, bus_out, end_process,
        output dm_out, status, host_rdata, host_valid, timeout, addr_err
    );
endinterface

// File: rtl/dm_controller.sv
// Byte-wide data memory plus run-control sequencer (IDLE/RUN/DONE/DUMP) with a run watchdog.
// Optional feature: define DM_BOUNDS_CHECK_EN to drop and flag out-of-range core accesses.
module dm_controller #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 65535
) (
    input  logic           clk,
    input  logic           rst,
    dm_controller_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        DUMP = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cycleCnt_q, cycleCnt_d;
    logic [AW-1:0] dumpCnt_q, dumpCnt_d;
    logic [7:0]    dmOut_q, dmOut_d;
    logic [7:0]    hostRdata_q, hostRdata_d;
    logic          hostValid_q, hostValid_d;
    logic          timeout_q, timeout_d;
    logic          addrErr_q, addrErr_d;

    logic [7:0]    mem [DEPTH];
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [7:0]    memWdata;
    logic [AW-1:0] coreAddr;
    logic          coreOob;
    logic          unusedBits;

    assign coreAddr = bus.dar_out[AW-1:0];

`ifdef DM_BOUNDS_CHECK_EN
    assign coreOob    = (32'(bus.dar_out) >= 32'(DEPTH));
    assign unusedBits = ^bus.bus_out[15:8];
`else
    assign coreOob    = 1'b0;
    assign unusedBits = ^{bus.dar_out[15:AW], bus.bus_out[15:8]};
`endif

    always_comb begin
        state_d     = state_q;
        cycleCnt_d  = cycleCnt_q;
        dumpCnt_d   = dumpCnt_q;
        dmOut_d     = coreOob ? 8'h00 : mem[coreAddr];
        hostRdata_d = hostRdata_q;
        hostValid_d = 1'b0;
        timeout_d   = timeout_q;
        addrErr_d   = addrErr_q;
        memWe       = 1'b0;
        memWaddr    = coreAddr;
        memWdata    = bus.bus_out[7:0];

        case (state_q)
            IDLE: begin
                if (bus.host_we) begin
                    memWe    = 1'b1;
                    memWaddr = bus.host_addr;
                    memWdata = bus.host_wdata;
                end
                if (bus.start) begin
                    state_d    = RUN;
                    cycleCnt_d = '0;
                    timeout_d  = 1'b0;
                    addrErr_d  = 1'b0;
                end
            end
            RUN: begin
                cycleCnt_d = cycleCnt_q + 16'd1;
                if (coreOob) begin
                    addrErr_d = 1'b1;
                end else if (bus.dm_en) begin
                    memWe = 1'b1;
                end
                // The watchdog takes priority so a coincident end_process still reports the timeout.
                if (cycleCnt_q == 16'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (bus.end_process) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.dump) begin
                    state_d   = DUMP;
                    dumpCnt_d = '0;
                end else if (bus.start) begin
                    state_d    = RUN;
                    cycleCnt_d = '0;
                    timeout_d  = 1'b0;
                    addrErr_d  = 1'b0;
                end
            end
            DUMP: begin
                hostRdata_d = mem[dumpCnt_q];
                hostValid_d = 1'b1;
                dumpCnt_d   = dumpCnt_q + 1'b1;
                if (dumpCnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cycleCnt_q  <= '0;
            dumpCnt_q   <= '0;
            dmOut_q     <= '0;
            hostRdata_q <= '0;
            hostValid_q <= 1'b0;
            timeout_q   <= 1'b0;
            addrErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycleCnt_q  <= cycleCnt_d;
            dumpCnt_q   <= dumpCnt_d;
            dmOut_q     <= dmOut_d;
            hostRdata_q <= hostRdata_d;
            hostValid_q <= hostValid_d;
            timeout_q   <= timeout_d;
            addrErr_q   <= addrErr_d;
        end
    end

    // Memory is deliberately left out of reset so an aborted run keeps its partial results.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[memWaddr] <= memWdata;
        end
    end

    assign bus.dm_out     = dmOut_q;
    assign bus.status     = state_q;
    assign bus.host_rdata = hostRdata_q;
    assign bus.host_valid = hostValid_q;
    assign bus.timeout    = timeout_q;
    assign bus.addr_err   = addrErr_q;
endmodule

// File: tb/tb_dm_controller.sv
// Randomized self-checking bench for dm_controller against a byte-array memory model.
// Runs with a short watchdog (TIMEOUT=20); expectations adapt when DM_BOUNDS_CHECK_EN is defined.
module tb_dm_controller;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 20;
    localparam int AW      = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    dm_controller_if #(.AW(AW)) dmIf ();

    dm_controller #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dmIf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs, then lets one clock edge pass and settles for sampling.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic st, input logic dp, input logic en,
                                 input logic [15:0] dar, input logic [15:0] bo, input logic ep);
        dmIf.host_we     = we;
        dmIf.host_addr   = addr;
        dmIf.host_wdata  = wdata;
        dmIf.start       = st;
        dmIf.dump        = dp;
        dmIf.dm_en       = en;
        dmIf.dar_out     = dar;
        dmIf.bus_out     = bo;
        dmIf.end_process = ep;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats;
        int runCycles;
        logic [7:0]  d;
        logic [7:0]  a;
        logic        en;
        logic [7:0]  expData;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("resetStatus", 32'(dmIf.status), 32'h0);
        checkOutput("resetDmOut", 32'(dmIf.dm_out), 32'h0);
        checkOutput("resetRdata", 32'(dmIf.host_rdata), 32'h0);
        checkOutput("resetValid", 32'(dmIf.host_valid), 32'h0);
        checkOutput("resetTimeout", 32'(dmIf.timeout), 32'h0);
        checkOutput("resetAddrErr", 32'(dmIf.addr_err), 32'h0);
        rst = 1'b0;

        $display("[TB] preloading memory with random bytes");
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            model[i] = d;
            applyStimulus(1, 8'(i), d, 0, 0, 0, 16'h0, 16'h0, 0);
        end
        checkOutput("preloadStatus", 32'(dmIf.status), 32'h0);

        model[5] = 8'hA7;
        applyStimulus(1, 8'd5, 8'hA7, 1, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("startStatus", 32'(dmIf.status), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 16'd5, 16'h0, 0);
        checkOutput("readPreload", 32'(dmIf.dm_out), 32'hA7);

        expData = model[3];
        applyStimulus(0, 0, 0, 0, 0, 1, 16'd3, 16'h12C4, 0);
        checkOutput("readDuringWriteOld", 32'(dmIf.dm_out), 32'(expData));
        model[3] = 8'hC4;
        applyStimulus(0, 0, 0, 0, 0, 0, 16'd3, 16'h0, 0);
        checkOutput("readAfterWrite", 32'(dmIf.dm_out), 32'hC4);

        for (int i = 0; i < 12; i++) begin
            en = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, DEPTH - 1));
            d  = 8'($urandom);
            expData = model[a];
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0, 0, en,
                          {8'h00, a}, {8'($urandom), d}, 0);
            checkOutput("runRandomRead", 32'(dmIf.dm_out), 32'(expData));
            if (en) model[a] = d;
        end
        checkOutput("runStatus", 32'(dmIf.status), 32'h1);

        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("endProcessStatus", 32'(dmIf.status), 32'h2);
        checkOutput("endProcessTimeout", 32'(dmIf.timeout), 32'h0);

        expData = model[7];
        applyStimulus(1, 8'd9, 8'($urandom), 0, 0, 1, 16'd7, 16'($urandom), 0);
        checkOutput("doneReadOnly", 32'(dmIf.dm_out), 32'(expData));
        checkOutput("doneStatusHeld", 32'(dmIf.status), 32'h2);

        applyStimulus(0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 0);
        checkOutput("dumpWinsStatus", 32'(dmIf.status), 32'h3);
        beats = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (beats < DEPTH)
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                              16'h0, 16'h0, 0);
            else
                applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
            if (dmIf.host_valid) begin
                if (beats < DEPTH) checkOutput("dumpData", 32'(dmIf.host_rdata), 32'(model[beats]));
                beats++;
                if (beats == DEPTH) checkOutput("dumpLastBeatStatus", 32'(dmIf.status), 32'h0);
            end else if (beats > 0) begin
                break;
            end
        end
        checkOutput("dumpBeatCount", 32'(beats), 32'(DEPTH));
        checkOutput("dumpEndValid", 32'(dmIf.host_valid), 32'h0);
        checkOutput("dumpEndStatus", 32'(dmIf.status), 32'h0);

        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("timeoutRunStatus", 32'(dmIf.status), 32'h1);
        runCycles = 1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
            if (dmIf.status == 2'b01) runCycles++;
            else break;
        end
        checkOutput("timeoutRunCycles", 32'(runCycles), 32'(TIMEOUT));
        checkOutput("timeoutStatus", 32'(dmIf.status), 32'h2);
        checkOutput("timeoutFlag", 32'(dmIf.timeout), 32'h1);

        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("restartClearsTimeout", 32'(dmIf.timeout), 32'h0);
        checkOutput("restartStatus", 32'(dmIf.status), 32'h1);
        for (int c = 1; c < TIMEOUT; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        end
        checkOutput("preTimeoutStatus", 32'(dmIf.status), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("bothEventsStatus", 32'(dmIf.status), 32'h2);
        checkOutput("bothEventsTimeout", 32'(dmIf.timeout), 32'h1);

        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 0);
        d = 8'($urandom);
        expData = model[5];
        applyStimulus(0, 0, 0, 0, 0, 1, 16'h0105, {8'h5A, d}, 0);
`ifdef DM_BOUNDS_CHECK_EN
        checkOutput("oobReadZero", 32'(dmIf.dm_out), 32'h0);
        checkOutput("oobAddrErr", 32'(dmIf.addr_err), 32'h1);
`else
        checkOutput("wrapReadOld", 32'(dmIf.dm_out), 32'(expData));
        checkOutput("wrapAddrErr", 32'(dmIf.addr_err), 32'h0);
        model[5] = d;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 16'd5, 16'h0, 0);
        checkOutput("wrapTargetRead", 32'(dmIf.dm_out), 32'(model[5]));
        applyStimulus(0, 0, 0, 0, 0, 0, 16'd5, 16'h0, 1);
        checkOutput("oobRunEndStatus", 32'(dmIf.status), 32'h2);
`ifdef DM_BOUNDS_CHECK_EN
        checkOutput("addrErrSticky", 32'(dmIf.addr_err), 32'h1);
`else
        checkOutput("addrErrTiedLow", 32'(dmIf.addr_err), 32'h0);
`endif

        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0);
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 10; cyc++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
            if (dmIf.host_valid) begin
                checkOutput("partialDumpData", 32'(dmIf.host_rdata), 32'(model[beats]));
                beats++;
            end
        end
        checkOutput("beatsBeforeReset", 32'(beats), 32'd10);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("abortStatus", 32'(dmIf.status), 32'h0);
        checkOutput("abortValid", 32'(dmIf.host_valid), 32'h0);
        checkOutput("abortRdata", 32'(dmIf.host_rdata), 32'h0);
        checkOutput("abortTimeout", 32'(dmIf.timeout), 32'h0);
        rst = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 16'd3, 16'h0, 0);
        checkOutput("keptMem3", 32'(dmIf.dm_out), 32'(model[3]));
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, DEPTH - 1));
            applyStimulus(0, 0, 0, 0, 0, 0, {8'h00, a}, 16'h0, 0);
            checkOutput("keptMemRandom", 32'(dmIf.dm_out), 32'(model[a]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
